// File: rtl/ahb_two_master_arbiter.sv
// Two-master AHB-lite arbiter in front of a single slave port: round-robin ownership, zero-latency forwarding.
// Optional grant parking on PARK_MASTER is enabled by defining AHB_ARB_PARK_EN.
module ahb_two_master_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int PARK_MASTER = 0
) (
  input  logic                  h_clk,
  input  logic                  h_reset,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [2:0]            m0_burst,
  input  logic [2:0]            m0_size,
  input  logic [1:0]            m0_trans,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_ready,
  output logic                  m0_resp,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [2:0]            m1_burst,
  input  logic [2:0]            m1_size,
  input  logic [1:0]            m1_trans,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_ready,
  output logic                  m1_resp,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [2:0]            s_burst,
  output logic [2:0]            s_size,
  output logic [1:0]            s_trans,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic                  s_ready,
  input  logic                  s_resp
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic       PARK_IDX     = PARK_MASTER[0];

`ifdef AHB_ARB_PARK_EN
  localparam logic RESET_GRANT = PARK_IDX;
  localparam logic RESET_VALID = 1'b1;
`else
  localparam logic RESET_GRANT = 1'b0;
  localparam logic RESET_VALID = 1'b0;
  logic unused_park;
  assign unused_park = PARK_IDX;
`endif

  logic grant, grant_valid, last_win;
  logic req0, req1, any_req, winner, owner_idle, rearb;

  // Request decode and winner selection; a tie goes to the master that did not win last.
  always_comb begin
    req0       = (m0_trans == TRANS_NONSEQ);
    req1       = (m1_trans == TRANS_NONSEQ);
    any_req    = req0 | req1;
    owner_idle = grant ? (m1_trans == TRANS_IDLE) : (m0_trans == TRANS_IDLE);
    // Handover only once the owner's data phase finishes, so nothing is in flight across it.
    rearb      = s_ready & (~grant_valid | owner_idle);
    if (req0 && req1) begin
      winner = ~last_win;
    end else begin
      winner = req1;
    end
  end

  // Grant state: changes only on a re-arbitration edge.
  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      grant       <= RESET_GRANT;
      grant_valid <= RESET_VALID;
      last_win    <= 1'b1;
    end else if (rearb) begin
      if (any_req) begin
        grant       <= winner;
        grant_valid <= 1'b1;
        last_win    <= winner;
      end else begin
`ifdef AHB_ARB_PARK_EN
        grant       <= PARK_IDX;
        grant_valid <= 1'b1;
`else
        grant_valid <= 1'b0;
`endif
      end
    end
  end

  // Forward path to the slave and return paths to both masters.
  always_comb begin
    s_addr   = '0;
    s_burst  = 3'b000;
    s_size   = 3'b000;
    s_trans  = TRANS_IDLE;
    s_write  = 1'b0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b1;
    m0_resp  = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b1;
    m1_resp  = 1'b0;
    m1_rdata = '0;
    if (h_reset) begin
      s_trans = TRANS_IDLE;
    end else begin
      if (grant_valid && grant) begin
        s_addr  = m1_addr;
        s_burst = m1_burst;
        s_size  = m1_size;
        s_trans = m1_trans;
        s_write = m1_write;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end else if (grant_valid) begin
        s_addr  = m0_addr;
        s_burst = m0_burst;
        s_size  = m0_size;
        s_trans = m0_trans;
        s_write = m0_write;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end else begin
        s_trans = TRANS_IDLE;
      end
      if (grant_valid && !grant) begin
        m0_ready = s_ready;
        m0_resp  = s_resp;
        m0_rdata = s_rdata;
      end else begin
        m0_ready = (m0_trans == TRANS_IDLE);
      end
      if (grant_valid && grant) begin
        m1_ready = s_ready;
        m1_resp  = s_resp;
        m1_rdata = s_rdata;
      end else begin
        m1_ready = (m1_trans == TRANS_IDLE);
      end
    end
  end

endmodule
